gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank: RTL and testbench

Parametrised multi-bit muxed-scan register bank with a synchronous active-low initialise to a per-bit preset pattern, forming one internal scan segment (SI to SO). It adds a shift-length tracker with a completion pulse and an optional update/shadow stage, so a segment can be shifted without disturbing functional outputs. It sits in the mcu9t5v0 library as the wide successor to the single-bit set-type scan flop, for configuration and observation registers in DFT-instrumented blocks.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__sdffsnq_pkg.sv | 24 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__scan_cnt.sv | 49 ++++
 rtl/gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank.sv | 76 +++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sdffsnq_pkg.sv
// Shared types and limits for the muxed-scan register bank: shift FSM encoding, width range, preset helper.
// No logic: latency n/a, backpressure n/a.
package gf180mcu_fd_sc_mcu9t5v0__sdffsnq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFTING = 2'd1,
    FULL     = 2'd2
  } scan_state_e;

  localparam logic [1:0] ST_IDLE     = 2'(IDLE);
  localparam logic [1:0] ST_SHIFTING = 2'(SHIFTING);
  localparam logic [1:0] ST_FULL     = 2'(FULL);

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  // All-ones preset of w bits keeps the set-type flop behaviour on every bit.
  function automatic logic [63:0] default_preset(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_cnt.sv
// Consecutive-shift tracker: saturating count to WIDTH with a single SHIFT_DONE pulse on reaching it.
// Latency: outputs registered, 1 cycle after the shift edge; backpressure: none, SE=0 clears.
module gf180mcu_fd_sc_mcu9t5v0__scan_cnt
  import gf180mcu_fd_sc_mcu9t5v0__sdffsnq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             SE,
  output logic [CNT_W-1:0] SHIFT_CNT,
  output logic             SHIFT_DONE
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0] state;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state      <= ST_IDLE;
      SHIFT_CNT  <= '0;
      SHIFT_DONE <= 1'b0;
    end else if (!SE) begin
      state      <= ST_IDLE;
      SHIFT_CNT  <= '0;
      SHIFT_DONE <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_SHIFTING: begin
          SHIFT_CNT  <= SHIFT_CNT + CNT_W'(1);
          SHIFT_DONE <= (SHIFT_CNT == LAST);
          state      <= (SHIFT_CNT == LAST) ? ST_FULL : ST_SHIFTING;
        end
        ST_FULL: begin
          // Data keeps moving but the count is saturated and the pulse is spent.
          SHIFT_DONE <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          SHIFT_CNT  <= '0;
          SHIFT_DONE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank.sv
// Muxed-scan register bank (SI->SO segment) with sync active-low preset; optional shadow via GF180MCU_SDFFSNQ_BANK_SHADOW_EN.
// Latency: Q/SO 1 cycle after capture; backpressure: none.
module gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank
  import gf180mcu_fd_sc_mcu9t5v0__sdffsnq_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(default_preset(WIDTH)),
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             SE,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  input  logic             UPDATE,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic [CNT_W-1:0] SHIFT_CNT,
  output logic             SHIFT_DONE
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("sdffsnq_bank: WIDTH out of range 1..64");
  end

  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] shift_next;

  if (WIDTH == 1) begin : g_shift_w1
    assign shift_next = SI;
  end else begin : g_shift_wn
    assign shift_next = {chain[WIDTH-2:0], SI};
  end

  always_ff @(posedge CLK) begin
    if (!RN)
      chain <= RESET_VAL;
    else if (SE)
      chain <= shift_next;
    else if (EN)
      chain <= D;
  end

  assign SO = chain[WIDTH-1];

`ifdef GF180MCU_SDFFSNQ_BANK_SHADOW_EN
  logic [WIDTH-1:0] shadow;

  // Shadow only captures in functional mode, so Q is frozen while a segment shifts.
  always_ff @(posedge CLK) begin
    if (!RN)
      shadow <= RESET_VAL;
    else if (UPDATE && !SE)
      shadow <= chain;
  end

  assign Q = shadow;
`else
  logic unused_update;
  assign unused_update = UPDATE;
  assign Q = chain;
`endif

  gf180mcu_fd_sc_mcu9t5v0__scan_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_scan_cnt (
    .CLK        (CLK),
    .RN         (RN),
    .SE         (SE),
    .SHIFT_CNT  (SHIFT_CNT),
    .SHIFT_DONE (SHIFT_DONE)
  );

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank.sv
// Self-checking bench for the scan register bank: WIDTH=8 instance against a behavioural model, plus a WIDTH=1 instance.
module tb_gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rn = 1'b1, se = 1'b0, en = 1'b0, si = 1'b0, upd = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       so;
  logic [3:0] cnt;
  logic       done;

  // WIDTH=1 instance
  logic       rn1 = 1'b1, se1 = 1'b0, en1 = 1'b0, si1 = 1'b0, upd1 = 1'b0;
  logic [0:0] d1 = 1'b0;
  logic [0:0] q1;
  logic       so1;
  logic [0:0] cnt1;
  logic       done1;

  gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank #(.WIDTH(8)) dut8 (
    .CLK(clk), .RN(rn), .SE(se), .EN(en), .D(d), .SI(si), .UPDATE(upd),
    .Q(q), .SO(so), .SHIFT_CNT(cnt), .SHIFT_DONE(done)
  );

  gf180mcu_fd_sc_mcu9t5v0__sdffsnq_bank #(.WIDTH(1)) dut1 (
    .CLK(clk), .RN(rn1), .SE(se1), .EN(en1), .D(d1), .SI(si1), .UPDATE(upd1),
    .Q(q1), .SO(so1), .SHIFT_CNT(cnt1), .SHIFT_DONE(done1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for the 8-bit bank, kept as plain integers.
  int m_chain  = 255;
  int m_shadow = 255;
  int m_cnt    = 0;
  int m_done   = 0;
  localparam int W = 8;

  function automatic int model_q();
`ifdef GF180MCU_SDFFSNQ_BANK_SHADOW_EN
    return m_shadow;
`else
    return m_chain;
`endif
  endfunction

  task automatic step8(input logic r, input logic s, input logic e,
                       input logic [7:0] dd, input logic i, input logic u);
    rn = r; se = s; en = e; d = dd; si = i; upd = u;
    @(posedge clk);
    if (!r) begin
      m_chain = 255; m_shadow = 255; m_cnt = 0; m_done = 0;
    end else if (s) begin
      m_done  = (m_cnt == W - 1) ? 1 : 0;
      m_cnt   = (m_cnt + 1 > W) ? W : m_cnt + 1;
      m_chain = (m_chain * 2 + int'(i)) % 256;
    end else begin
      m_done = 0;
      m_cnt  = 0;
      if (u) m_shadow = m_chain;
      if (e) m_chain = int'(dd);
    end
    #1;
  endtask

  task automatic step1(input logic r, input logic s, input logic i);
    rn1 = r; se1 = s; si1 = i; en1 = 1'b0; upd1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step8(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (q !== 8'hFF) begin n_bad++; $display("FAIL reset_q got=%h want=ff", q); end
    n_cmp++; if (so !== 1'b1) begin n_bad++; $display("FAIL reset_so got=%b want=1", so); end
    n_cmp++; if (cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
  endtask

  task automatic test_load();
    step8(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    step8(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    n_cmp++; if (q !== 8'hA5) begin n_bad++; $display("FAIL load_hold got=%h want=a5", q); end
    n_cmp++; if (so !== 1'b1) begin n_bad++; $display("FAIL load_so got=%b want=1", so); end
  endtask

  task automatic test_shift_through();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    step8(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step8(1'b1, 1'b1, 1'b0, 8'h00, pat[8-k], 1'b0);
      n_cmp++; if (cnt !== 4'(k)) begin n_bad++; $display("FAIL shift_cnt edge=%0d got=%0d want=%0d", k, cnt, k); end
      n_cmp++; if (done !== (k == 8)) begin n_bad++; $display("FAIL shift_done edge=%0d got=%b want=%b", k, done, (k == 8)); end
    end
    n_cmp++; if (q !== 8'(model_q())) begin n_bad++; $display("FAIL shift_q got=%h want=%h", q, 8'(model_q())); end
    n_cmp++; if (so !== 1'b1) begin n_bad++; $display("FAIL shift_so got=%b want=1", so); end
`ifndef GF180MCU_SDFFSNQ_BANK_SHADOW_EN
    n_cmp++; if (q !== 8'hB2) begin n_bad++; $display("FAIL shift_b2 got=%h want=b2", q); end
`endif
    step8(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (cnt !== 4'd8) begin n_bad++; $display("FAIL shift9_cnt got=%0d want=8", cnt); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL shift9_done got=%b want=0", done); end
    // SO must replay the pattern: bit k appears 7 edges after it entered.
    n_cmp++; if (so !== 1'b0) begin n_bad++; $display("FAIL shift9_so got=%b want=0", so); end
  endtask

  task automatic test_mid_reset();
    step8(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step8(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step8(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (q !== 8'hFF) begin n_bad++; $display("FAIL midrst_q got=%h want=ff", q); end
    n_cmp++; if (cnt !== 4'd0) begin n_bad++; $display("FAIL midrst_cnt got=%0d want=0", cnt); end
    for (int k = 1; k <= 4; k++) begin
      step8(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      n_cmp++; if (done !== 1'b0 || cnt !== 4'(k)) begin
        n_bad++; $display("FAIL midrst_after edge=%0d done=%b cnt=%0d want done=0 cnt=%0d", k, done, cnt, k);
      end
    end
  endtask

  task automatic test_shadow();
    logic [7:0] pat;
    pat = 8'h5A;
    step8(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    step8(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (q !== 8'hA5) begin n_bad++; $display("FAIL shadow_pre got=%h want=a5", q); end
    for (int k = 7; k >= 0; k--) begin
      step8(1'b1, 1'b1, 1'b0, 8'h00, pat[k], 1'b1);
`ifdef GF180MCU_SDFFSNQ_BANK_SHADOW_EN
      n_cmp++; if (q !== 8'hA5) begin n_bad++; $display("FAIL shadow_frozen bit=%0d got=%h want=a5", k, q); end
`else
      n_cmp++; if (q !== 8'(model_q())) begin n_bad++; $display("FAIL shadow_follow bit=%0d got=%h want=%h", k, q, 8'(model_q())); end
`endif
    end
    step8(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (q !== 8'h5A) begin n_bad++; $display("FAIL shadow_update got=%h want=5a", q); end
  endtask

  task automatic test_random();
    logic r, s, e, i, u;
    logic [7:0] dd;
    int bad_here;
    bad_here = 0;
    for (int c = 0; c < 300; c++) begin
      r  = ($urandom_range(0, 19) != 0);
      s  = ($urandom_range(0, 5) != 0);
      e  = $urandom_range(0, 1) == 1;
      i  = $urandom_range(0, 1) == 1;
      u  = $urandom_range(0, 1) == 1;
      dd = 8'($urandom);
      step8(r, s, e, dd, i, u);
      n_cmp++;
      if (q !== 8'(model_q()) || so !== 1'(m_chain >> 7) ||
          cnt !== 4'(m_cnt) || done !== 1'(m_done)) begin
        n_bad++;
        if (bad_here < 5)
          $display("FAIL random cyc=%0d q=%h so=%b cnt=%0d done=%b want q=%h so=%b cnt=%0d done=%0d",
                   c, q, so, cnt, done, 8'(model_q()), 1'(m_chain >> 7), m_cnt, m_done);
        bad_here++;
      end
    end
  endtask

  task automatic test_width1();
    step1(1'b0, 1'b1, 1'b1);
    n_cmp++; if (so1 !== 1'b1 || cnt1 !== 1'd0 || done1 !== 1'b0) begin
      n_bad++; $display("FAIL w1_reset so=%b cnt=%0d done=%b want 1 0 0", so1, cnt1, done1);
    end
    step1(1'b1, 1'b1, 1'b0);
    n_cmp++; if (so1 !== 1'b0) begin n_bad++; $display("FAIL w1_so got=%b want=0", so1); end
    n_cmp++; if (cnt1 !== 1'd1 || done1 !== 1'b1) begin
      n_bad++; $display("FAIL w1_done cnt=%0d done=%b want 1 1", cnt1, done1);
    end
    step1(1'b1, 1'b1, 1'b1);
    n_cmp++; if (so1 !== 1'b1 || cnt1 !== 1'd1 || done1 !== 1'b0) begin
      n_bad++; $display("FAIL w1_sat so=%b cnt=%0d done=%b want 1 1 0", so1, cnt1, done1);
    end
    step1(1'b1, 1'b0, 1'b0);
    n_cmp++; if (cnt1 !== 1'd0 || done1 !== 1'b0 || so1 !== 1'b1) begin
      n_bad++; $display("FAIL w1_idle so=%b cnt=%0d done=%b want 1 0 0", so1, cnt1, done1);
    end
    step1(1'b1, 1'b1, 1'b0);
    n_cmp++; if (cnt1 !== 1'd1 || done1 !== 1'b1 || so1 !== 1'b0) begin
      n_bad++; $display("FAIL w1_restart so=%b cnt=%0d done=%b want 0 1 1", so1, cnt1, done1);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_shift_through();
    test_mid_reset();
    test_shadow();
    test_random();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
